tlu_trigger_fifo: RTL and testbench
===================================

TLU_TRIGGER_FIFO -- requirements
Module: tlu_trigger_fifo

Interface
REQ-001: Parameter DEPTH, default 8, FIFO depth in words; power of two, 2..256.
REQ-002: Parameter NEAR_FULL_THRESHOLD, default 6, fill level at and above which FIFO_NEAR_FULL asserts; range 1..DEPTH.
REQ-003: The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-004: BUS_CLK  input  1  sole clock; all logic on the rising edge.
REQ-005: BUS_RST_N  input  1  asynchronous active-low reset.
REQ-006: CLEAR  input  1  synchronous flush of FIFO contents and lost counter.
REQ-007: TLU_DATA  input  32  trigger data word, valid while TLU_DATA_SAVE_FLAG is high.
REQ-008: TLU_DATA_SAVE_FLAG  input  1  single-cycle pulse requesting storage of TLU_DATA.
REQ-009: TLU_DATA_SAVED_FLAG  output  1  single-cycle acknowledge pulse to the upstream handshake.
REQ-010: FIFO_READ  input  1  pop request from the readout side.
REQ-011: FIFO_DATA  output  32  head word, first-word fall-through.
REQ-012: FIFO_EMPTY  output  1  no word stored.
REQ-013: FIFO_FULL  output  1  DEPTH words stored.
REQ-014: FIFO_NEAR_FULL  output  1  fill level >= NEAR_FULL_THRESHOLD.
REQ-015: FILL_LEVEL  output  clog2(DEPTH)+1  current word count.
REQ-016: LOST_COUNT  output  8  number of triggers dropped while full; saturating.

Function
REQ-017: Stored word format: bit 31 forced to 1 as the trigger marker; bits 30:0 taken from TLU_DATA[30:0]; TLU_DATA[31] ignored.
REQ-018: Write: TLU_DATA_SAVE_FLAG=1 with FIFO_FULL=0 stores the word at the write pointer, which advances by one modulo DEPTH.
REQ-019: Ack: TLU_DATA_SAVED_FLAG is registered and pulses high for exactly one cycle, one cycle after every TLU_DATA_SAVE_FLAG pulse, whether the word was stored or dropped, so the upstream handshake never stalls.
REQ-020: Drop: TLU_DATA_SAVE_FLAG=1 with FIFO_FULL=1 and FIFO_READ=0 discards the word and increments LOST_COUNT, saturating at 255.
REQ-021: Read: FIFO_READ=1 with FIFO_EMPTY=0 advances the read pointer modulo DEPTH; FIFO_DATA then shows the next word in the same cycle the pointer updates.
REQ-022: FIFO_READ=1 with FIFO_EMPTY=1 is ignored: no pointer or count change, no error.
REQ-023: Simultaneous read and write, not empty: both are performed and FILL_LEVEL is unchanged.
REQ-024: Simultaneous read and write when full: the read frees a slot, so the write is accepted, no drop, and FILL_LEVEL stays DEPTH.
REQ-025: Simultaneous read and write when empty: only the write is performed and FILL_LEVEL becomes 1.
REQ-026: FILL_LEVEL, FIFO_EMPTY, FIFO_FULL and FIFO_NEAR_FULL are registered and reflect the operations of the previous clock edge.
REQ-027: FIFO_DATA is undefined-but-stable when FIFO_EMPTY=1; the verification bench ignores it in that state.
REQ-028: Pointer wrap-around is transparent; word order is strictly FIFO across any number of wraps.
REQ-029: CLEAR=1 zeroes both pointers, FILL_LEVEL and LOST_COUNT at the next edge; a coincident write or read is discarded without incrementing LOST_COUNT, but the write is still acknowledged per REQ-019.
REQ-030: Storage is a synchronous-write memory array; no reset of array contents is required.

Reset
REQ-031: While BUS_RST_N=0, the outputs are: TLU_DATA_SAVED_FLAG=0, FIFO_EMPTY=1, FIFO_FULL=0, FIFO_NEAR_FULL=0, FILL_LEVEL=0, LOST_COUNT=0, and both pointers 0.
REQ-032: Reset assertion is asynchronous; deassertion is synchronous to BUS_CLK, and no operation occurs on the first edge after release.
REQ-033: A reset asserted mid-operation discards all stored words and any pending acknowledge.

Verification
REQ-034: Single write: write 0x0000_1234, then read -> TLU_DATA_SAVED_FLAG high exactly at cycle +1; FIFO_DATA=0x8000_1234; FIFO_EMPTY returns to 1 after the pop.
REQ-035: Fill and overflow (DEPTH=8): write 10 words with TLU_DATA=1..10, no reads -> FIFO_FULL=1, LOST_COUNT=2, 10 acks; reads return 0x8000_0001..0x8000_0008 in order.
REQ-036: Near-full: write 5 words -> FIFO_NEAR_FULL=0; sixth write -> FIFO_NEAR_FULL=1 one cycle later; one read -> FIFO_NEAR_FULL=0.
REQ-037: Full with simultaneous read and write: while full, pulse write and read together -> LOST_COUNT unchanged, FILL_LEVEL=8, the new word is the last one read out.
REQ-038: Saturation, wrap and CLEAR: 300 writes while full -> LOST_COUNT=255; 20 interleaved write/read pairs -> data order preserved across wraps; CLEAR -> FILL_LEVEL=0, LOST_COUNT=0.
REQ-039: Reset mid-operation: assert BUS_RST_N=0 with 4 words stored -> FIFO_EMPTY=1 immediately, without waiting for a clock edge; no TLU_DATA_SAVED_FLAG pulse appears after release.

Source files
------------

// File: rtl/tlu_trigger_fifo.sv
// tlu_trigger_fifo
// Trigger-word FIFO between the TLU handshake and the readout bus.
// Every TLU_DATA_SAVE_FLAG pulse gets an acknowledge one cycle later.
// The word is stored with bit 31 forced high as a trigger marker.
// If the FIFO is full, the word is dropped and LOST_COUNT increments.
//
// Ports:
//   BUS_CLK             sole clock, rising edge
//   BUS_RST_N           asynchronous active-low reset
//   CLEAR               synchronous flush of contents and lost counter
//   TLU_DATA            trigger word, valid with TLU_DATA_SAVE_FLAG
//   TLU_DATA_SAVE_FLAG  store request pulse
//   TLU_DATA_SAVED_FLAG registered acknowledge pulse
//   FIFO_READ           pop request
//   FIFO_DATA           head word (first-word fall-through)
//   FIFO_EMPTY          no word stored
//   FIFO_FULL           DEPTH words stored
//   FIFO_NEAR_FULL      fill level >= NEAR_FULL_THRESHOLD
//   FILL_LEVEL          current word count
//   LOST_COUNT          dropped-trigger count, saturating at 255
module tlu_trigger_fifo #(
   parameter int unsigned DEPTH               = 8,
   parameter int unsigned NEAR_FULL_THRESHOLD = 6
) (
   input  logic                     BUS_CLK,
   input  logic                     BUS_RST_N,
   input  logic                     CLEAR,
   input  logic [31:0]              TLU_DATA,
   input  logic                     TLU_DATA_SAVE_FLAG,
   output logic                     TLU_DATA_SAVED_FLAG,
   input  logic                     FIFO_READ,
   output logic [31:0]              FIFO_DATA,
   output logic                     FIFO_EMPTY,
   output logic                     FIFO_FULL,
   output logic                     FIFO_NEAR_FULL,
   output logic [$clog2(DEPTH):0]   FILL_LEVEL,
   output logic [7:0]               LOST_COUNT
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] NF_W    = (AW+1)'(NEAR_FULL_THRESHOLD);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   fill_q, fill_d;
   logic [7:0]    lost_q, lost_d;
   logic          empty_q, full_q, nf_q;
   logic          ack_q;
   logic          run_q;     // low for the first edge after reset release
   logic          rd_en, wr_en, drop;

   // Only bits 30:0 of the trigger word are stored.
   logic          unused_data_msb;
   assign unused_data_msb = TLU_DATA[31];

   always_comb begin
      rd_en = run_q && !CLEAR && FIFO_READ && !empty_q;
      // A coincident pop frees a slot, so a full FIFO still accepts the write.
      wr_en = run_q && !CLEAR && TLU_DATA_SAVE_FLAG && (!full_q || rd_en);
      drop  = run_q && !CLEAR && TLU_DATA_SAVE_FLAG && full_q && !FIFO_READ;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      lost_d   = lost_q;

      if (run_q && CLEAR) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
         lost_d   = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
         if (wr_en && !rd_en)      fill_d = fill_q + 1'b1;
         else if (rd_en && !wr_en) fill_d = fill_q - 1'b1;
         if (drop && lost_q != 8'hFF) lost_d = lost_q + 1'b1;
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         run_q    <= 1'b0;
         ack_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         lost_q   <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         nf_q     <= 1'b0;
      end else begin
         run_q    <= 1'b1;
         ack_q    <= run_q && TLU_DATA_SAVE_FLAG;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         lost_q   <= lost_d;
         empty_q  <= (fill_d == '0);
         full_q   <= (fill_d == DEPTH_W);
         nf_q     <= (fill_d >= NF_W);
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (wr_en) mem[wr_ptr_q] <= {1'b1, TLU_DATA[30:0]};
   end

   assign FIFO_DATA           = mem[rd_ptr_q];
   assign TLU_DATA_SAVED_FLAG = ack_q;
   assign FIFO_EMPTY          = empty_q;
   assign FIFO_FULL           = full_q;
   assign FIFO_NEAR_FULL      = nf_q;
   assign FILL_LEVEL          = fill_q;
   assign LOST_COUNT          = lost_q;

endmodule

// File: tb/tb_tlu_trigger_fifo.sv
// Directed bench for tlu_trigger_fifo (DEPTH=8, NEAR_FULL_THRESHOLD=6).
// A queue of expected words is filled on accepted writes and drained on pops.
module tb_tlu_trigger_fifo;

   localparam int DEPTH = 8;
   localparam int NFT   = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] tdata = '0;
   logic        save = 1'b0;
   logic        ack;
   logic        rd = 1'b0;
   logic [31:0] fdata;
   logic        empty, full, nfull;
   logic [3:0]  fill;
   logic [7:0]  lost;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb[$];
   int          m_fill = 0;
   int          m_lost = 0;
   bit          hold = 0;

   always #5 clk = ~clk;

   tlu_trigger_fifo #(.DEPTH(DEPTH), .NEAR_FULL_THRESHOLD(NFT)) dut (
      .BUS_CLK(clk), .BUS_RST_N(rst_n), .CLEAR(clear),
      .TLU_DATA(tdata), .TLU_DATA_SAVE_FLAG(save), .TLU_DATA_SAVED_FLAG(ack),
      .FIFO_READ(rd), .FIFO_DATA(fdata), .FIFO_EMPTY(empty), .FIFO_FULL(full),
      .FIFO_NEAR_FULL(nfull), .FILL_LEVEL(fill), .LOST_COUNT(lost)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag);
      chk({tag, ".fill"},  32'(fill),  32'(m_fill));
      chk({tag, ".empty"}, 32'(empty), 32'(m_fill == 0));
      chk({tag, ".full"},  32'(full),  32'(m_fill == DEPTH));
      chk({tag, ".nfull"}, 32'(nfull), 32'(m_fill >= NFT));
      chk({tag, ".lost"},  32'(lost),  32'(m_lost));
      if (m_fill != 0) chk({tag, ".head"}, fdata, sb[0]);
   endtask

   // One clock cycle with the given inputs; model advances, then outputs checked.
   task automatic step(input string tag, input logic s, input logic [31:0] d,
                       input logic r, input logic c);
      bit rd_ok, wr_ok, drp;
      save = s; tdata = d; rd = r; clear = c;
      rd_ok = r && (m_fill > 0);
      wr_ok = s && ((m_fill < DEPTH) || rd_ok);
      drp   = s && (m_fill == DEPTH) && !r;
      if (rd_ok && !c && !hold) chk({tag, ".pop"}, fdata, sb[0]);
      @(posedge clk); #1;
      save = 1'b0; rd = 1'b0; clear = 1'b0;
      if (!hold) begin
         if (c) begin
            sb.delete(); m_fill = 0; m_lost = 0;
         end else begin
            if (rd_ok) begin void'(sb.pop_front()); m_fill--; end
            if (wr_ok) begin sb.push_back({1'b1, d[30:0]}); m_fill++; end
            if (drp && m_lost < 255) m_lost++;
         end
      end
      chk({tag, ".ack"}, 32'(ack), 32'(s && !hold));
      chk_status(tag);
   endtask

   initial begin
      logic [31:0] w;
      // Reset state while held in reset
      #12;
      chk_status("rst");
      chk("rst.ack", 32'(ack), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      // First edge after release performs nothing, even with a request
      hold = 1;
      step("first_edge", 1'b1, 32'h0000_00AA, 1'b1, 1'b0);
      hold = 0;
      step("idle", 1'b0, '0, 1'b0, 1'b0);

      // Single write then read
      step("single_wr", 1'b1, 32'h0000_1234, 1'b0, 1'b0);
      chk("single_head", fdata, 32'h8000_1234);
      step("single_ack_gone", 1'b0, '0, 1'b0, 1'b0);
      step("single_rd", 1'b0, '0, 1'b1, 1'b0);
      step("rd_empty", 1'b0, '0, 1'b1, 1'b0);

      // Fill and overflow: 10 writes, 2 dropped
      for (int i = 1; i <= 10; i++) step("fill_wr", 1'b1, 32'(i), 1'b0, 1'b0);
      chk("overflow_lost", 32'(lost), 32'd2);
      for (int i = 1; i <= 8; i++) begin
         chk("fill_order", fdata, 32'h8000_0000 | 32'(i));
         step("fill_rd", 1'b0, '0, 1'b1, 1'b0);
      end

      // Near-full threshold crossing
      for (int i = 0; i < 5; i++) step("nf_wr", 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      chk("nf_below", 32'(nfull), 32'd0);
      step("nf_sixth", 1'b1, 32'h105, 1'b0, 1'b0);
      chk("nf_at", 32'(nfull), 32'd1);
      step("nf_rd", 1'b0, '0, 1'b1, 1'b0);
      chk("nf_after_rd", 32'(nfull), 32'd0);

      // Full with simultaneous read and write
      for (int i = 0; i < 3; i++) step("top_up", 1'b1, 32'hF000_0200 + 32'(i), 1'b0, 1'b0);
      chk("is_full", 32'(full), 32'd1);
      step("full_rw", 1'b1, 32'h0000_0077, 1'b1, 1'b0);
      chk("full_rw_fill", 32'(fill), 32'd8);
      chk("full_rw_lost", 32'(lost), 32'd2);
      for (int i = 0; i < 8; i++) step("full_drain", 1'b0, '0, 1'b1, 1'b0);

      // Empty with simultaneous read and write: only the write happens
      step("empty_rw", 1'b1, 32'h0000_0055, 1'b1, 1'b0);
      chk("empty_rw_fill", 32'(fill), 32'd1);

      // Saturation of the lost counter
      for (int i = 0; i < 7; i++) step("sat_fill", 1'b1, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) step("sat_wr", 1'b1, $urandom, 1'b0, 1'b0);
      chk("sat_lost", 32'(lost), 32'd255);

      // Interleaved traffic across pointer wraps
      for (int i = 0; i < 5; i++) step("wrap_drain", 1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         w = $urandom;
         step("wrap_wr", 1'b1, w, 1'b0, 1'b0);
         step("wrap_rd", 1'b0, '0, 1'b1, 1'b0);
         step("wrap_rw", 1'b1, ~w, 1'b1, 1'b0);
      end

      // CLEAR with coincident write: acked, discarded, no loss counted
      step("clear", 1'b1, 32'h0000_0999, 1'b1, 1'b1);
      chk("clear_fill", 32'(fill), 32'd0);
      chk("clear_lost", 32'(lost), 32'd0);
      step("post_clear", 1'b0, '0, 1'b0, 1'b0);

      // Reset mid-operation with an acknowledge pending
      for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_empty", 32'(empty), 32'd1);
      chk("async_fill", 32'(fill), 32'd0);
      chk("async_ack", 32'(ack), 32'd0);
      sb.delete(); m_fill = 0; m_lost = 0;
      @(posedge clk); #1; rst_n = 1'b1;
      hold = 1;
      step("rel_first", 1'b0, '0, 1'b0, 1'b0);
      hold = 0;
      step("rel_idle", 1'b0, '0, 1'b0, 1'b0);
      step("rel_wr", 1'b1, 32'h0000_0ABC, 1'b0, 1'b0);
      step("rel_rd", 1'b0, '0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
